// File: rtl/alu_defs.sv
// Shared codes for the ALU command sequencer: op codes, response error codes
// and the sequencer state encoding.
package alu_defs;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_t;

  // Add/sub produce a W-bit result; only mul/div use the full 2*W bus.
  function automatic logic op_is_narrow(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small command FIFO: registered count drives full/empty, head is read
// combinationally from the storage array. Pointers wrap naturally since
// DEPTH is a power of two.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Host-side initiator for the multi-cycle ALU: queues commands, issues them
// one at a time, captures the result (or flags div-by-zero / timeout) and
// returns it on a valid/ready response channel.
module alu_cmd_sequencer
  import alu_defs::*;
#(
  parameter int W         = 8,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [2*W-1:0] cmd_a,
  input  logic [W-1:0]   cmd_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data,
  output logic [1:0]     res_op,
  output logic [1:0]     res_err,
  output logic [1:0]     alu_op,
  output logic [2*W-1:0] alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_start,
  input  logic           alu_finish,
  input  logic [2*W-1:0] alu_result,
  output logic           busy
);

  localparam int FW  = 2 + 3*W;
  localparam int WDW = $clog2(TIMEOUT) + 1;
  // Exit on the edge where the watchdog would reach TIMEOUT-1, so the
  // timeout response appears exactly TIMEOUT cycles after alu_start.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);

  seq_state_t     state;
  seq_state_t     state_n;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic [FW-1:0]  head;
  logic [1:0]     head_op;
  logic [2*W-1:0] head_a;
  logic [W-1:0]   head_b;
  logic           head_div0;

  logic [1:0]     op_q;
  logic [2*W-1:0] a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] data_q;
  logic [2*W-1:0] data_n;
  logic [1:0]     err_q;
  logic [1:0]     err_n;
  logic           issued_q;
  logic           issued_n;
  logic [WDW-1:0] wd_q;

  cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data ({cmd_op, cmd_a, cmd_b}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_op, head_a, head_b} = head;
  assign head_div0 = (head_op == OP_DIV) && (head_b == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next state, FIFO pop and response values.
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    data_n   = data_q;
    err_n    = err_q;
    issued_n = issued_q;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_div0) begin
            // Caught locally: the ALU never sees this command.
            state_n  = ST_RESP;
            data_n   = '0;
            err_n    = ERR_DIV0;
            issued_n = 1'b0;
          end else begin
            state_n  = ST_ISSUE;
            issued_n = 1'b1;
          end
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        // Finish takes priority over a coincident watchdog expiry.
        if (alu_finish) begin
          state_n = ST_RESP;
          err_n   = ERR_OK;
          data_n  = op_is_narrow(op_q) ? {{W{1'b0}}, alu_result[W-1:0]} : alu_result;
        end else if (wd_q == WD_LAST) begin
          state_n = ST_RESP;
          err_n   = ERR_TMO;
          data_n  = '0;
        end
      end
      ST_RESP: begin
        if (res_ready) state_n = issued_q ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        // Let the ALU fall back to idle before the next start.
        if (!alu_finish) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Command and response registers; operands stay put from ISSUE through RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      err_q    <= ERR_OK;
      issued_q <= 1'b0;
    end else begin
      if (pop) begin
        op_q <= head_op;
        a_q  <= head_a;
        b_q  <= head_b;
      end
      data_q   <= data_n;
      err_q    <= err_n;
      issued_q <= issued_n;
    end
  end

  // Watchdog: cleared on issue, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst)                   wd_q <= '0;
    else if (state == ST_ISSUE) wd_q <= '0;
    else if (state == ST_WAIT)  wd_q <= wd_q + 1'b1;
  end

  assign cmd_ready = !fifo_full;
  assign res_valid = (state == ST_RESP);
  assign res_data  = data_q;
  assign res_op    = op_q;
  assign res_err   = err_q;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_start = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a behavioural ALU responder plus
// an expected-response queue filled from the arithmetic rules of each command.
module tb_alu_cmd_sequencer;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [2*W-1:0] cmd_a;
  logic [W-1:0]   cmd_b;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] res_data;
  logic [1:0]     res_op;
  logic [1:0]     res_err;
  logic [1:0]     alu_op;
  logic [2*W-1:0] alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_start;
  logic           alu_finish;
  logic [2*W-1:0] alu_result;
  logic           busy;

  alu_cmd_sequencer #(.W(W), .CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_op     (res_op),
    .res_err    (res_err),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_start  (alu_start),
    .alu_finish (alu_finish),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   starts = 0;

  // ALU responder knobs, set by the stimulus.
  int alu_lat   = 3;
  int alu_hold  = 1;
  bit alu_hang  = 1'b0;
  bit force_fin = 1'b0;
  int cnt_m;
  int hold_m;
  bit busy_m;

  // Raw ALU behaviour: add/sub keep carry/borrow in the upper byte, mul is signed.
  function automatic logic [15:0] alu_calc(input logic [1:0] op, input logic [15:0] a,
                                           input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = $signed(a[7:0]);
    sb = $signed(b);
    case (op)
      2'b00:   return {8'h00, a[7:0]} + {8'h00, b};
      2'b01:   return {8'h00, a[7:0]} - {8'h00, b};
      2'b10:   return sa * sb;
      default: return (b == 8'h00) ? 16'hDEAD : {8'(a % {8'h00, b}), 8'(a / {8'h00, b})};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      busy_m     <= 1'b0;
      alu_finish <= 1'b0;
      cnt_m      <= 0;
      hold_m     <= 0;
      alu_result <= '0;
    end else if (force_fin) begin
      alu_finish <= 1'b1;
      busy_m     <= 1'b0;
    end else if (alu_start) begin
      busy_m     <= 1'b1;
      cnt_m      <= alu_lat;
      alu_finish <= 1'b0;
      alu_result <= alu_calc(alu_op, alu_a, alu_b);
    end else if (busy_m && !alu_hang) begin
      if (alu_finish) begin
        if (hold_m <= 1) begin
          alu_finish <= 1'b0;
          busy_m     <= 1'b0;
        end else hold_m <= hold_m - 1;
      end else if (cnt_m <= 1) begin
        alu_finish <= 1'b1;
        hold_m     <= alu_hold;
      end else cnt_m <= cnt_m - 1;
    end else begin
      alu_finish <= 1'b0;
    end
  end

  // Expected response from the command alone, using integer arithmetic.
  function automatic exp_t expect_of(input logic [1:0] op, input logic [15:0] a,
                                     input logic [7:0] b, input bit hang);
    exp_t e;
    int ia, ib, sa, sb;
    e.op = op; e.err = 2'b00; e.data = '0;
    ia = int'(a[7:0]);
    ib = int'(b);
    if (op == 2'b11 && ib == 0) begin e.err = 2'b01; return e; end
    if (hang) begin e.err = 2'b10; return e; end
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    case (op)
      2'b00:   e.data = 16'((ia + ib) % 256);
      2'b01:   e.data = 16'((ia - ib + 256) % 256);
      2'b10:   e.data = 16'((sa * sb) & 32'hFFFF);
      default: e.data = 16'(((int'(a) % ib) * 256) + ((int'(a) / ib) % 256));
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample just after the edge. Every start must see finish low.
  task automatic tick();
    @(posedge clk); #1;
    if (alu_start === 1'b1) begin
      starts++;
      chk("start_vs_finish", 32'(alu_finish), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                      output bit ok);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    ok = cmd_ready;
    tick();
    cmd_valid = 1'b0;
    if (ok) expq.push_back(expect_of(op, a, b, alu_hang));
  endtask

  task automatic push_must(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b);
    bit ok;
    int tries;
    ok = 1'b0; tries = 0;
    while (!ok && tries < 100) begin push(op, a, b, ok); tries++; end
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic collect(input int n, input string tag);
    int   got;
    int   guard;
    exp_t e;
    got = 0; guard = 0;
    res_ready = 1'b1;
    while (got < n && guard < 2000) begin
      if (res_valid === 1'b1) begin
        if (expq.size() == 0) chk({tag, "_unexpected"}, 32'(res_valid), 32'd0);
        else begin
          e = expq.pop_front();
          chk({tag, "_op"},   32'(res_op),   32'(e.op));
          chk({tag, "_data"}, 32'(res_data), 32'(e.data));
          chk({tag, "_err"},  32'(res_err),  32'(e.err));
        end
        got++;
      end
      tick();
      guard++;
    end
    res_ready = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int       s0, k, acc;
    bit       ok, stable, seen;
    logic [25:0] rec;
    logic [1:0]  rop;
    logic [15:0] ra;
    logic [7:0]  rb;

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    idle(2);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_res_err",   32'(res_err),   32'd0);
    chk("rst_alu_a",     32'(alu_a),     32'd0);
    rst = 1'b1;

    // add: two-cycle issue latency, one start, finish->valid in one cycle
    alu_lat = 3; alu_hold = 1;
    s0 = starts;
    push_must(2'b00, 16'h0005, 8'h03);
    chk("lat_early", 32'(alu_start), 32'd0);
    tick();
    chk("lat_start", 32'(alu_start), 32'd1);
    k = 0;
    while (alu_finish !== 1'b1 && k < 100) begin tick(); k++; end
    tick();
    chk("fin_to_valid", 32'(res_valid), 32'd1);
    collect(1, "add");
    chk("add_starts", 32'(starts - s0), 32'd1);

    // divide by zero never touches the ALU
    idle(4);
    s0 = starts;
    push_must(2'b11, 16'h0064, 8'h00);
    tick();
    chk("div0_valid", 32'(res_valid), 32'd1);
    collect(1, "div0");
    idle(3);
    chk("div0_starts", 32'(starts - s0), 32'd0);

    // signed mul, operands held for the whole wait
    idle(4);
    alu_lat = 10;
    push_must(2'b10, 16'h00FD, 8'h04);
    tick();
    chk("mul_start", 32'(alu_start), 32'd1);
    rec = {alu_op, alu_a, alu_b};
    stable = 1'b1; k = 0;
    while (alu_finish !== 1'b1 && k < 100) begin
      tick(); k++;
      if ({alu_op, alu_a, alu_b} !== rec) stable = 1'b0;
    end
    chk("mul_stable", 32'(stable), 32'd1);
    chk("mul_operand_a", 32'(alu_a), 32'h00FD);
    collect(1, "mul");

    // backpressure: one in flight plus DEPTH queued, then cmd_ready drops
    idle(4);
    alu_lat = 2; alu_hold = 2; acc = 0;
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3)); ra = 16'($urandom); rb = 8'($urandom_range(0, 255));
      push(rop, ra, rb, ok);
      acc += int'(ok);
    end
    chk("bp_accepted", 32'(acc), 32'(DEPTH + 1));
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    collect(DEPTH + 1, "bp");

    // timeout: exact latency, then drain waits for finish to go low
    idle(5);
    alu_hang = 1'b1;
    push_must(2'b00, 16'h0001, 8'h01);
    tick();
    chk("tmo_start", 32'(alu_start), 32'd1);
    k = 0;
    while (res_valid !== 1'b1 && k < 200) begin tick(); k++; end
    chk("tmo_latency", 32'(k), 32'(TMO));
    force_fin = 1'b1; alu_hang = 1'b0;
    push_must(2'b01, 16'h0020, 8'h30);
    collect(1, "tmo");
    s0 = starts;
    idle(6);
    chk("drain_hold", 32'(starts - s0), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    force_fin = 1'b0;
    collect(1, "after_tmo");

    // reset while waiting on the ALU drops everything
    idle(4);
    alu_lat = 20; alu_hold = 1;
    push_must(2'b00, 16'h0011, 8'h22);
    push_must(2'b10, 16'h0007, 8'h09);
    push_must(2'b11, 16'h0100, 8'h03);
    idle(4);
    rst = 1'b0;
    tick();
    chk("rstw_res_valid", 32'(res_valid), 32'd0);
    chk("rstw_busy",      32'(busy),      32'd0);
    chk("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b1;
    expq.delete();
    s0 = starts; seen = 1'b0;
    res_ready = 1'b1;
    repeat (40) begin tick(); if (res_valid === 1'b1) seen = 1'b1; end
    res_ready = 1'b0;
    chk("rstw_no_stale", 32'(seen), 32'd0);
    chk("rstw_no_start", 32'(starts - s0), 32'd0);

    // random single commands with varied ALU latency and finish hold
    for (int i = 0; i < 12; i++) begin
      alu_lat = $urandom_range(1, 8); alu_hold = $urandom_range(1, 3);
      rop = 2'($urandom_range(0, 3)); ra = 16'($urandom); rb = 8'($urandom_range(0, 255));
      if (i == 5) rb = 8'h00;
      push_must(rop, ra, rb);
      collect(1, "rnd");
    end

    // random burst queued behind a stalled response
    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 3)); ra = 16'($urandom); rb = 8'($urandom_range(1, 255));
      push_must(rop, ra, rb);
    end
    collect(4, "burst");
    idle(5);
    chk("end_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
